regwr_arbiter: RTL and testbench

REGWR_ARBITER -- requirements
Module: regwr_arbiter

---
 rtl/regwr_arbiter.sv | 79 +++++++
 tb/tb_regwr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant under contention,
// one-cycle registered write port, and a saturating contention counter.
module regwr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              req0_valid_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_data_i,
    output logic              req1_ready_o,
    output logic              RegWrite_o,
    output logic [ADDR_W-1:0] RDaddr_o,
    output logic [DATA_W-1:0] RDdata_o,
    output logic [7:0]        conflict_cnt_o
);

    logic              last_grant;
    logic              contend;
    logic              grant0;
    logic              grant1;
    logic              transfer;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // last_grant = 1 means requester 1 won most recently, so requester 0 wins the next contention
    always_comb begin
        contend = req0_valid_i && req1_valid_i;
        grant0  = 1'b0;
        grant1  = 1'b0;
        if (!rst_i && !stall_i) begin
            if (contend) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign transfer     = grant0 || grant1;
    assign sel_addr     = grant1 ? req1_addr_i : req0_addr_i;
    assign sel_data     = grant1 ? req1_data_i : req0_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
            RegWrite_o <= 1'b0;
            RDaddr_o   <= '0;
            RDdata_o   <= '0;
        end else if (transfer) begin
            last_grant <= grant1;
            RegWrite_o <= (sel_addr != '0);
            RDaddr_o   <= sel_addr;
            RDdata_o   <= sel_data;
        end else begin
            RegWrite_o <= 1'b0;
        end
    end

    // Stalled cycles are not counted as contention
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= 8'd0;
        end else if (contend && !stall_i && (conflict_cnt_o != 8'hFF)) begin
            conflict_cnt_o <= conflict_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed bench for regwr_arbiter: a transaction-level model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_regwr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          stall_i = 1'b0;
    logic          req0_valid_i = 1'b0;
    logic [AW-1:0] req0_addr_i = '0;
    logic [DW-1:0] req0_data_i = '0;
    logic          req0_ready_o;
    logic          req1_valid_i = 1'b0;
    logic [AW-1:0] req1_addr_i = '0;
    logic [DW-1:0] req1_data_i = '0;
    logic          req1_ready_o;
    logic          RegWrite_o;
    logic [AW-1:0] RDaddr_o;
    logic [DW-1:0] RDdata_o;
    logic [7:0]    conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    regwr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .stall_i        (stall_i),
        .req0_valid_i   (req0_valid_i),
        .req0_addr_i    (req0_addr_i),
        .req0_data_i    (req0_data_i),
        .req0_ready_o   (req0_ready_o),
        .req1_valid_i   (req1_valid_i),
        .req1_addr_i    (req1_addr_i),
        .req1_data_i    (req1_data_i),
        .req1_ready_o   (req1_ready_o),
        .RegWrite_o     (RegWrite_o),
        .RDaddr_o       (RDaddr_o),
        .RDdata_o       (RDdata_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: who should win this cycle, and what the write port shows afterwards
    logic          m_last_was1;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    int            m_cnt;
    logic [1:0]    m_win;
    logic [DW-1:0] rf_shadow [32];

    function automatic logic [1:0] modelWinner(input logic v0, input logic v1,
                                               input logic st, input logic rs,
                                               input logic last_was1);
        if (rs || st) return 2'b00;
        if (v0 && v1) return last_was1 ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    assign m_win = modelWinner(req0_valid_i, req1_valid_i, stall_i, rst_i, m_last_was1);

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_last_was1 <= 1'b1;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_data      <= '0;
            m_cnt       <= 0;
        end else begin
            if (m_win == 2'b01) begin
                m_last_was1 <= 1'b0;
                m_we        <= (req0_addr_i != 0);
                m_addr      <= req0_addr_i;
                m_data      <= req0_data_i;
            end else if (m_win == 2'b10) begin
                m_last_was1 <= 1'b1;
                m_we        <= (req1_addr_i != 0);
                m_addr      <= req1_addr_i;
                m_data      <= req1_data_i;
            end else begin
                m_we <= 1'b0;
            end
            if (req0_valid_i && req1_valid_i && !stall_i)
                m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
        end
    end

    always @(posedge clk_i) begin
        if (RegWrite_o) rf_shadow[RDaddr_o] <= RDdata_o;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        checkOutput("ready0", 64'(req0_ready_o), 64'(m_win[0]));
        checkOutput("ready1", 64'(req1_ready_o), 64'(m_win[1]));
        checkOutput("RegWrite", 64'(RegWrite_o), 64'(m_we));
        checkOutput("RDaddr", 64'(RDaddr_o), 64'(m_addr));
        checkOutput("RDdata", 64'(RDdata_o), 64'(m_data));
        checkOutput("conflict_cnt", 64'(conflict_cnt_o), 64'(m_cnt));
    end

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic st);
        req0_valid_i = v0;
        req0_addr_i  = a0;
        req0_data_i  = d0;
        req1_valid_i = v1;
        req1_addr_i  = a1;
        req1_data_i  = d1;
        stall_i      = st;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        applyStimulus(1'b1, 5'd5, 32'h1, 1'b0, '0, '0, 1'b0);
        nextCycle();
        checkOutput("rst ready0", 64'(req0_ready_o), 64'd0);
        checkOutput("rst RegWrite", 64'(RegWrite_o), 64'd0);
        checkOutput("rst cnt", 64'(conflict_cnt_o), 64'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        rst_i = 1'b0;
        nextCycle();

        // Contention straight after reset: requester 0 first
        applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
        #1;
        checkOutput("cont ready0", 64'(req0_ready_o), 64'd1);
        checkOutput("cont ready1", 64'(req1_ready_o), 64'd0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd4, 32'h22, 1'b0);
        checkOutput("cont wr1 addr", 64'(RDaddr_o), 64'd3);
        checkOutput("cont wr1 data", 64'(RDdata_o), 64'h11);
        checkOutput("cont cnt1", 64'(conflict_cnt_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("cont wr2 we", 64'(RegWrite_o), 64'd1);
        checkOutput("cont wr2 addr", 64'(RDaddr_o), 64'd4);
        checkOutput("cont cnt2", 64'(conflict_cnt_o), 64'd1);

        // Write to register 0 is accepted but suppressed
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
        #1;
        checkOutput("x0 ready1", 64'(req1_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("x0 we", 64'(RegWrite_o), 64'd0);
        checkOutput("x0 addr", 64'(RDaddr_o), 64'd0);

        // Single request
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
        #1;
        checkOutput("single ready0", 64'(req0_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("single we", 64'(RegWrite_o), 64'd1);
        checkOutput("single addr", 64'(RDaddr_o), 64'd5);
        checkOutput("single data", 64'(RDdata_o), 64'hDEADBEEF);

        // Stall for three cycles, then round-robin resumes (req0 won last, so req1 next)
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b1);
        for (int i = 0; i < 3; i++) nextCycle();
        checkOutput("stall ready0", 64'(req0_ready_o), 64'd0);
        checkOutput("stall we", 64'(RegWrite_o), 64'd0);
        checkOutput("stall cnt", 64'(conflict_cnt_o), 64'd1);
        stall_i = 1'b0;
        #1;
        checkOutput("unstall ready1", 64'(req1_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("unstall cnt", 64'(conflict_cnt_o), 64'd2);

        // Same destination from both: req0 then req1, req1's data survives
        applyStimulus(1'b1, 5'd9, 32'hAAAA, 1'b1, 5'd9, 32'hBBBB, 1'b0);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'hBBBB, 1'b0);
        checkOutput("same data1", 64'(RDdata_o), 64'hAAAA);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        nextCycle();
        checkOutput("same rf9", 64'(rf_shadow[9]), 64'hBBBB);
        checkOutput("same cnt", 64'(conflict_cnt_o), 64'd3);

        // Long contention drives the counter into saturation
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, AW'(1 + (i % 15)), DW'(i), 1'b1, AW'(16 + (i % 15)), DW'(32'h1000 + i), 1'b0);
            nextCycle();
        end
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        checkOutput("sat cnt", 64'(conflict_cnt_o), 64'd255);
        nextCycle();
        checkOutput("sat hold", 64'(conflict_cnt_o), 64'd255);

        // Reset in the middle of a transfer cycle
        applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, '0, '0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("midrst ready0", 64'(req0_ready_o), 64'd0);
        checkOutput("midrst addr", 64'(RDaddr_o), 64'd0);
        checkOutput("midrst data", 64'(RDdata_o), 64'd0);
        checkOutput("midrst cnt", 64'(conflict_cnt_o), 64'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        nextCycle();
        rst_i = 1'b0;
        nextCycle();
        checkOutput("postrst we", 64'(RegWrite_o), 64'd0);
        checkOutput("postrst addr", 64'(RDaddr_o), 64'd0);
        applyStimulus(1'b1, 5'd12, 32'hC, 1'b1, 5'd13, 32'hD, 1'b0);
        #1;
        checkOutput("postrst ready0", 64'(req0_ready_o), 64'd1);
        nextCycle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        nextCycle();
        nextCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
